// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin arbiter sharing one combinational-read memory port between instruction fetch and data access.
// Latency: request sampled in IDLE at edge N, memory access in cycle N+1, one-cycle ack in cycle N+2 (one transaction per 3 cycles).
// Backpressure: requesters hold req until ack; the losing port simply waits, at most one transaction, for the next IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,

    // instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,

    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,

    // shared memory port
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;

    state_t state;
    port_t  grant;
    port_t  last_grant;
    port_t  winner;
    logic   d_reject;

    // Round-robin pick: a lone requester wins; on a tie the port that did not win last time goes.
    always_comb begin
        winner = PORT_I;
        if (if_req && d_req) begin
            winner = (last_grant == PORT_D) ? PORT_I : PORT_D;
        end else if (d_req) begin
            winner = PORT_D;
        end
    end

    // Stores with an unknown width or a misaligned halfword/word address never reach memory.
    always_comb begin
        d_reject = 1'b0;
        if (d_we) begin
            if (d_funct3 > F3_SW) begin
                d_reject = 1'b1;
            end else if ((d_funct3 == F3_SH) && d_addr[0]) begin
                d_reject = 1'b1;
            end else if ((d_funct3 == F3_SW) && (d_addr[1:0] != 2'b00)) begin
                d_reject = 1'b1;
            end
        end
    end

    // Memory port is driven only during ACCESS; combinational so an async reset drops mem_write at once.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_funct3 = 3'd0;
        mem_addr   = '0;
        mem_wdata  = 32'd0;
        if (state == ST_ACCESS) begin
            if (grant == PORT_I) begin
                mem_read   = 1'b1;
                mem_funct3 = F3_SW;
                mem_addr   = if_addr;
            end else begin
                mem_read   = !d_we;
                mem_write  = d_we && !d_reject;
                mem_funct3 = d_funct3;
                mem_addr   = d_addr;
                mem_wdata  = d_wdata;
            end
        end
    end

    // Arbitration FSM with registered acks and per-port response data that holds until that port's next response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            grant      <= PORT_I;
            last_grant <= PORT_D;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= 32'd0;
            d_rdata    <= 32'd0;
            d_err      <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (if_req || d_req) begin
                        grant      <= winner;
                        last_grant <= winner;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    state <= ST_RESP;
                    if (grant == PORT_I) begin
                        if_ack   <= 1'b1;
                        if_rdata <= mem_rdata;
                    end else begin
                        d_ack   <= 1'b1;
                        d_rdata <= d_we ? 32'd0 : mem_rdata;
                        d_err   <= d_reject;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, giving the byte-address width of both request ports and the memory port.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port if_req, input, 1 bit: instruction-fetch request, held high until if_ack.
REQ-005 The block SHALL have port if_addr, input, ADDR_W bits: fetch byte address, stable while if_req is high.
REQ-006 The block SHALL have port if_ack, output, 1 bit: one-cycle fetch completion pulse.
REQ-007 The block SHALL have port if_rdata, output, 32 bits: fetched word, valid while if_ack is high.
REQ-008 The block SHALL have port d_req, input, 1 bit: data request, held high until d_ack.
REQ-009 The block SHALL have port d_we, input, 1 bit: 1 means store, 0 means load.
REQ-010 The block SHALL have port d_funct3, input, 3 bits: store width, where 0 means SB, 1 means SH and 2 means SW.
REQ-011 The block SHALL have port d_addr, input, ADDR_W bits: data byte address.
REQ-012 The block SHALL have port d_wdata, input, 32 bits: store data.
REQ-013 The block SHALL have port d_ack, output, 1 bit: one-cycle data completion pulse.
REQ-014 The block SHALL have port d_rdata, output, 32 bits: loaded word, valid while d_ack is high.
REQ-015 The block SHALL have port d_err, output, 1 bit: high with d_ack when the store was rejected.
REQ-016 The block SHALL have port mem_read, output, 1 bit: memory read enable.
REQ-017 The block SHALL have port mem_write, output, 1 bit: memory write enable.
REQ-018 The block SHALL have port mem_funct3, output, 3 bits: memory store width.
REQ-019 The block SHALL have port mem_addr, output, ADDR_W bits: memory byte address.
REQ-020 The block SHALL have port mem_wdata, output, 32 bits: memory write data.
REQ-021 The block SHALL have port mem_rdata, input, 32 bits: memory combinational read data.

Function
REQ-022 The FSM SHALL have exactly three states:
- IDLE to ACCESS when any request is high; the winner is latched as grant.
- ACCESS to RESP unconditionally.
- RESP to IDLE unconditionally; requests are ignored in RESP.
REQ-023 Arbitration SHALL be round-robin via a last_grant register:
- Only one request high: that requester wins.
- Both requests high: the requester not equal to last_grant wins.
- last_grant updates on the IDLE-to-ACCESS edge.
REQ-024 Memory controls SHALL be driven only in ACCESS; in IDLE and RESP, mem_read, mem_write, mem_addr, mem_wdata and mem_funct3 SHALL all be 0.
REQ-025 In ACCESS with a fetch grant the block SHALL drive:
- mem_read = 1 and mem_write = 0.
- mem_addr = if_addr and mem_funct3 = 3'h2.
- mem_wdata = 0.
REQ-026 In ACCESS with a data grant the block SHALL drive:
- mem_read = !d_we and mem_addr = d_addr.
- mem_funct3 = d_funct3 and mem_wdata = d_wdata.
- mem_write = d_we && !reject.
REQ-027 The reject condition SHALL be d_we and any of: d_funct3 > 2; SH with d_addr[0] = 1; SW with d_addr[1:0] != 0.
REQ-028 On the ACCESS-to-RESP edge, the block SHALL register:
- mem_rdata into the granted requester's rdata (0 for a store).
- reject into d_err.
REQ-029 In RESP, the granted requester's ack SHALL be 1 for exactly one cycle; the other ack SHALL be 0.
REQ-030 if_rdata, d_rdata and d_err SHALL hold their value until the next RESP of the same port.
REQ-031 Latency SHALL be: request sampled in IDLE at edge N, memory access in cycle N+1, ack high in cycle N+2; maximum throughput is one transaction per 3 cycles.
REQ-032 A requester SHALL be allowed to keep its request high at the ack edge to issue a new transaction; it is arbitrated in the following IDLE.
REQ-033 When both requests are continuously high, grants SHALL strictly alternate I, D, I, D and so on; no port waits more than one transaction.
REQ-034 At most one mem_write cycle SHALL occur per granted store; loads and fetches SHALL never assert mem_write.

Reset
REQ-035 While rst = 0, the block SHALL force, asynchronously:
- State = IDLE and last_grant = D, so that the first tie goes to fetch.
- All acks, d_err, if_rdata and d_rdata = 0.
- All mem_* outputs = 0.
REQ-036 A reset asserted in ACCESS SHALL abort the transaction: no ack is issued, and mem_write drops immediately; the write commits only if the rising clock edge precedes reset assertion.
REQ-037 After reset deassertion, a request still high SHALL be arbitrated as a new transaction.

Verification
REQ-038 The bench SHALL cover a single fetch: memory word 0 = 32'h04030201, if_req = 1, if_addr = 0 -> mem_read = 1 in cycle 1, if_ack = 1 in cycle 2, if_rdata = 32'h04030201.
REQ-039 The bench SHALL cover a tie after reset: if_req = d_req = 1 both held -> grant order I, D, I, D; if_ack in cycles 2 and 8, d_ack in cycles 5 and 11.
REQ-040 The bench SHALL cover an SB store: d_we = 1, d_funct3 = 0, d_addr = 5, d_wdata = 32'hAB -> one mem_write pulse in cycle 1; a subsequent load of address 4 returns byte 1 = 8'hAB; d_err = 0.
REQ-041 The bench SHALL cover rejected stores: SW at d_addr = 6 and funct3 = 3 at d_addr = 0 -> mem_write never asserted; d_ack = 1 with d_err = 1.
REQ-042 The bench SHALL cover reset during ACCESS of a store: rst = 0 mid-cycle 1 -> outputs zero immediately, no ack; after release, held d_req is re-served with ack 3 cycles later.
